// File: rtl/bkm_step_monitor.sv
// Two-stage CSD-to-two's-complement decoder for the X/Y results of a BKM step,
// with per-sample overflow and illegal-digit flags plus saturating sample counters.
module bkm_step_monitor #(
    parameter int WD = 64
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              srst,
    input  logic              enable,
    input  logic              valid_in,
    input  logic [2*WD-1:0]   X_n1_csd,
    input  logic [2*WD-1:0]   Y_n1_csd,
    output logic [WD-1:0]     tb_X_n1,
    output logic [WD-1:0]     tb_Y_n1,
    output logic              valid_out,
    output logic              illegal_flag,
    output logic              ovf_X,
    output logic              ovf_Y,
    output logic [15:0]       sample_cnt,
    output logic [15:0]       illegal_cnt
);

    // Per-digit split of each CSD word into +1 / -1 / illegal bit vectors.
    logic [WD-1:0] px_next, nx_next, py_next, ny_next;
    logic [WD-1:0] illx_vec, illy_vec;
    logic          ill_next;

    generate
        for (genvar gi = 0; gi < WD; gi++) begin : g_digit
            assign px_next[gi]  = (X_n1_csd[2*gi+1:2*gi] == 2'b01);
            assign nx_next[gi]  = (X_n1_csd[2*gi+1:2*gi] == 2'b11);
            assign illx_vec[gi] = (X_n1_csd[2*gi+1:2*gi] == 2'b10);
            assign py_next[gi]  = (Y_n1_csd[2*gi+1:2*gi] == 2'b01);
            assign ny_next[gi]  = (Y_n1_csd[2*gi+1:2*gi] == 2'b11);
            assign illy_vec[gi] = (Y_n1_csd[2*gi+1:2*gi] == 2'b10);
        end
    endgenerate

    assign ill_next = (|illx_vec) | (|illy_vec);

    // Stage 1 state
    logic [WD-1:0] px_reg, nx_reg, py_reg, ny_reg;
    logic          ill_reg;
    logic          v1_reg;

    // Stage 2 arithmetic: one extra bit so P - N never wraps.
    logic [WD:0] vx_next, vy_next;
    logic        ovfx_next, ovfy_next;

    always_comb begin
        vx_next   = {1'b0, px_reg} - {1'b0, nx_reg};
        vy_next   = {1'b0, py_reg} - {1'b0, ny_reg};
        // Out of WD-bit signed range exactly when the top two bits disagree.
        ovfx_next = vx_next[WD] ^ vx_next[WD-1];
        ovfy_next = vy_next[WD] ^ vy_next[WD-1];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            px_reg  <= '0;
            nx_reg  <= '0;
            py_reg  <= '0;
            ny_reg  <= '0;
            ill_reg <= 1'b0;
            v1_reg  <= 1'b0;
        end else if (srst) begin
            px_reg  <= '0;
            nx_reg  <= '0;
            py_reg  <= '0;
            ny_reg  <= '0;
            ill_reg <= 1'b0;
            v1_reg  <= 1'b0;
        end else if (enable) begin
            px_reg  <= px_next;
            nx_reg  <= nx_next;
            py_reg  <= py_next;
            ny_reg  <= ny_next;
            ill_reg <= ill_next;
            v1_reg  <= valid_in;
        end
    end

    // Stage 2: data and flags only load on valid samples so bubbles keep the last result.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tb_X_n1      <= '0;
            tb_Y_n1      <= '0;
            valid_out    <= 1'b0;
            illegal_flag <= 1'b0;
            ovf_X        <= 1'b0;
            ovf_Y        <= 1'b0;
        end else if (srst) begin
            tb_X_n1      <= '0;
            tb_Y_n1      <= '0;
            valid_out    <= 1'b0;
            illegal_flag <= 1'b0;
            ovf_X        <= 1'b0;
            ovf_Y        <= 1'b0;
        end else if (enable) begin
            valid_out <= v1_reg;
            if (v1_reg) begin
                tb_X_n1      <= vx_next[WD-1:0];
                tb_Y_n1      <= vy_next[WD-1:0];
                illegal_flag <= ill_reg;
                ovf_X        <= ovfx_next;
                ovf_Y        <= ovfy_next;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sample_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (srst) begin
            sample_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (enable && v1_reg) begin
            if (sample_cnt != 16'hFFFF) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (ill_reg && (illegal_cnt != 16'hFFFF)) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end
        end
    end

endmodule
